// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage.
// NOP encoding, default reset PC and fetch FSM states.
package if_fetch_unit_pkg;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, imem request FSM and a one-entry
// output buffer feeding the IF/ID register.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic [XLEN-1:0] if_addr_out,
  output logic [XLEN-1:0] if_instr_out,
  output logic            if_valid_out
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
  localparam logic [XLEN-1:0] NOP = XLEN'(INST_NOP);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic [XLEN-1:0] buf_addr_q, buf_addr_d;
  logic [XLEN-1:0] buf_instr_q, buf_instr_d;
  logic            buf_valid_q, buf_valid_d;
  logic            req_fire;
  logic            rsp_take;
  logic            unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc[1:0];

  // Request only when the buffer will be free by the time data returns.
  always_comb begin
    imem_req_valid = 1'b0;
    if (state_q == S_REQ) begin
      imem_req_valid = !reset && !redirect
                     && (!buf_valid_q || !stall);
    end
  end

  assign imem_req_addr = pc_q;
  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_take = (state_q == S_WAIT)
                  && imem_rsp_valid && !redirect;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_REQ:   if (req_fire) state_d = S_WAIT;
      S_WAIT: begin
        if (imem_rsp_valid) state_d = S_REQ;
        else if (redirect) state_d = S_DRAIN;
      end
      S_DRAIN: if (imem_rsp_valid) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    req_pc_d = req_pc_q;
    if (redirect) begin
      pc_d = {redirect_pc[XLEN-1:2], 2'b00};
    end else if (req_fire) begin
      pc_d = pc_q + PC_STEP;
      req_pc_d = pc_q;
    end
  end

  always_comb begin
    buf_addr_d = buf_addr_q;
    buf_instr_d = buf_instr_q;
    buf_valid_d = buf_valid_q;
    if (redirect) begin
      buf_valid_d = 1'b0;
    end else if (rsp_take) begin
      buf_addr_d = req_pc_q;
      buf_instr_d = imem_rsp_data;
      buf_valid_d = 1'b1;
    end else if (buf_valid_q && !stall) begin
      buf_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_REQ;
      pc_q <= RESET_PC;
      req_pc_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_addr_q <= '0;
      buf_instr_q <= NOP;
      buf_valid_q <= 1'b0;
    end else begin
      buf_addr_q <= buf_addr_d;
      buf_instr_q <= buf_instr_d;
      buf_valid_q <= buf_valid_d;
    end
  end

  assign if_valid_out = buf_valid_q && !reset;
  assign if_addr_out = if_valid_out ? buf_addr_q : '0;
  assign if_instr_out = if_valid_out ? buf_instr_q : NOP;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit.
// Memory model, consumption scoreboard and per-cycle vectors.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset, stall, redirect;
  logic [31:0] rpc;
  logic        rv, ready;
  logic [31:0] ra;
  logic        rspv;
  logic [31:0] rspd;
  logic [31:0] oa, oi;
  logic        ov;

  logic        reset2, stall2, redirect2;
  logic [31:0] rpc2;
  logic        rv2, ready2;
  logic [31:0] ra2;
  logic        rspv2;
  logic [31:0] rspd2;
  logic [31:0] oa2, oi2;
  logic        ov2;

  if_fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect(redirect), .redirect_pc(rpc),
    .imem_req_valid(rv), .imem_req_ready(ready),
    .imem_req_addr(ra), .imem_rsp_valid(rspv),
    .imem_rsp_data(rspd), .if_addr_out(oa),
    .if_instr_out(oi), .if_valid_out(ov)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .reset(reset2), .stall(stall2),
    .redirect(redirect2), .redirect_pc(rpc2),
    .imem_req_valid(rv2), .imem_req_ready(ready2),
    .imem_req_addr(ra2), .imem_rsp_valid(rspv2),
    .imem_rsp_data(rspd2), .if_addr_out(oa2),
    .if_instr_out(oi2), .if_valid_out(ov2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] ra;
    logic        v;
    logic [31:0] a;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] i;
  } exp_t;

  vec_t vt[14];
  exp_t sbq[$];

  int n_cmp = 0;
  int n_err = 0;
  int lat = 1;
  int cnt = 0;
  bit pend = 0;
  logic [31:0] maddr = '0;

  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'hA000_0013;
  endfunction

  function automatic vec_t mk(input logic s, input logic r,
                              input logic [31:0] q,
                              input logic v,
                              input logic [31:0] a);
    vec_t t;
    t.stall = s; t.rv = r; t.ra = q; t.v = v; t.a = a;
    return t;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic sb_push(input logic [31:0] a);
    exp_t e;
    e.a = a;
    e.i = f(a);
    sbq.push_back(e);
  endtask

  task automatic out_chk(input string nm, input logic v,
                         input logic [31:0] a);
    chk({nm, "_valid"}, 32'(ov), 32'(v));
    chk({nm, "_addr"}, oa, v ? a : 32'h0);
    chk({nm, "_instr"}, oi, v ? f(a) : NOP);
  endtask

  // One clock with a 1-entry memory model and consumption scoreboard.
  task automatic cyc();
    logic acc, cons, rst;
    logic [31:0] aa, ca, ci;
    exp_t e;
    acc = rv && ready;
    aa = ra;
    rst = reset;
    cons = ov && !stall && !redirect && !reset;
    ca = oa;
    ci = oi;
    @(posedge clk);
    #1;
    rspv = 1'b0;
    if (rst) begin
      pend = 0;
    end else begin
      if (acc) begin
        pend = 1; cnt = lat; maddr = aa;
      end
      if (pend) begin
        if (cnt <= 1) begin
          rspv = 1'b1; rspd = f(maddr); pend = 0;
        end else begin
          cnt--;
        end
      end
    end
    if (cons) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected", ca, 32'hFFFF_FFFF);
      end else begin
        e = sbq.pop_front();
        chk("sb_addr", ca, e.a);
        chk("sb_instr", ci, e.i);
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; stall = 1'b0; redirect = 1'b0;
    ready = 1'b1; lat = 1;
    #1;
    chk("rst_req_valid", 32'(rv), 32'h0);
    out_chk("rst", 1'b0, 32'h0);
    cyc();
    cyc();
    reset = 1'b0;
    sbq.delete();
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0;
    rpc = '0; ready = 1'b1; rspv = 1'b0; rspd = '0;
    reset2 = 1'b1; stall2 = 1'b0; redirect2 = 1'b0;
    rpc2 = '0; ready2 = 1'b1; rspv2 = 1'b0; rspd2 = '0;

    vt[0]  = mk(0, 1, 32'h00, 0, 32'h0);
    vt[1]  = mk(0, 0, 32'h04, 0, 32'h0);
    vt[2]  = mk(0, 1, 32'h04, 1, 32'h0);
    vt[3]  = mk(0, 0, 32'h08, 0, 32'h0);
    vt[4]  = mk(0, 1, 32'h08, 1, 32'h4);
    vt[5]  = mk(0, 0, 32'h0C, 0, 32'h0);
    for (int i = 6; i <= 10; i++)
      vt[i] = mk(1, 0, 32'h0C, 1, 32'h8);
    vt[11] = mk(0, 1, 32'h0C, 1, 32'h8);
    vt[12] = mk(0, 0, 32'h10, 0, 32'h0);
    vt[13] = mk(0, 1, 32'h10, 1, 32'hC);

    // Streaming fetch then a 5-cycle stall on 0x8.
    do_reset();
    sb_push(32'h0); sb_push(32'h4);
    sb_push(32'h8); sb_push(32'hC);
    for (int i = 0; i < 14; i++) begin
      stall = vt[i].stall;
      #1;
      chk($sformatf("t1_rv%0d", i), 32'(rv), 32'(vt[i].rv));
      chk($sformatf("t1_ra%0d", i), ra, vt[i].ra);
      out_chk($sformatf("t1_c%0d", i), vt[i].v, vt[i].a);
      cyc();
    end
    chk("t1_sb_drained", sbq.size(), 0);

    // Redirect during a slow response: drain and drop it.
    do_reset();
    lat = 3;
    #1; chk("t3_rv0", 32'(rv), 1); chk("t3_ra0", ra, 0);
    cyc();
    redirect = 1'b1; rpc = 32'h100;
    #1; chk("t3_rv1", 32'(rv), 0);
    cyc();
    redirect = 1'b0;
    #1; chk("t3_rv2", 32'(rv), 0);
    chk("t3_ra2", ra, 32'h100);
    out_chk("t3_c2", 0, 0);
    cyc();
    #1; chk("t3_rsp", 32'(rspv), 1);
    chk("t3_rv3", 32'(rv), 0);
    out_chk("t3_c3", 0, 0);
    cyc();
    lat = 1;
    #1; chk("t3_rv4", 32'(rv), 1);
    chk("t3_ra4", ra, 32'h100);
    out_chk("t3_c4", 0, 0);
    cyc();
    #1; out_chk("t3_c5", 0, 0);
    cyc();
    sb_push(32'h100);
    #1; out_chk("t3_c6", 1, 32'h100);
    cyc();
    chk("t3_sb_drained", sbq.size(), 0);

    // Redirect with response and stall in the same cycle.
    do_reset();
    #1; chk("t4_rv0", 32'(rv), 1); chk("t4_ra0", ra, 0);
    cyc();
    redirect = 1'b1; rpc = 32'h203; stall = 1'b1;
    #1; chk("t4_rsp", 32'(rspv), 1);
    chk("t4_rv1", 32'(rv), 0);
    cyc();
    redirect = 1'b0; stall = 1'b0;
    #1; out_chk("t4_c2", 0, 0);
    chk("t4_rv2", 32'(rv), 1);
    chk("t4_ra2", ra, 32'h200);
    cyc();
    #1; out_chk("t4_c3", 0, 0);
    cyc();
    #1; out_chk("t4_c4", 1, 32'h200);
    stall = 1'b1; redirect = 1'b1; rpc = 32'h300;
    #1; chk("t4_rv4", 32'(rv), 0);
    cyc();
    redirect = 1'b0; stall = 1'b0;
    #1; out_chk("t4_c5", 0, 0);
    chk("t4_rv5", 32'(rv), 1);
    chk("t4_ra5", ra, 32'h300);
    cyc();
    chk("t4_sb_drained", sbq.size(), 0);

    // Request back-pressure for 4 cycles.
    do_reset();
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t5_rv%0d", i), 32'(rv), 1);
      chk($sformatf("t5_ra%0d", i), ra, 0);
      out_chk($sformatf("t5_c%0d", i), 0, 0);
      cyc();
    end
    ready = 1'b1;
    #1; chk("t5_rv4", 32'(rv), 1); chk("t5_ra4", ra, 0);
    cyc();
    #1; chk("t5_rv5", 32'(rv), 0); chk("t5_ra5", ra, 4);
    cyc();
    sb_push(32'h0);
    #1; out_chk("t5_c6", 1, 32'h0);
    cyc();
    chk("t5_sb_drained", sbq.size(), 0);

    // PC wrap from 0xFFFF_FFFC and reset in the middle of a wait.
    reset = 1'b1;
    reset2 = 1'b0;
    #1; chk("t6_rv0", 32'(rv2), 1);
    chk("t6_ra0", ra2, 32'hFFFF_FFFC);
    chk("t6_v0", 32'(ov2), 0);
    cyc();
    rspv2 = 1'b1; rspd2 = f(32'hFFFF_FFFC);
    #1; chk("t6_rv1", 32'(rv2), 0);
    chk("t6_ra1", ra2, 32'h0);
    cyc();
    rspv2 = 1'b0;
    #1; chk("t6_v2", 32'(ov2), 1);
    chk("t6_a2", oa2, 32'hFFFF_FFFC);
    chk("t6_i2", oi2, f(32'hFFFF_FFFC));
    chk("t6_rv2", 32'(rv2), 1);
    chk("t6_ra2", ra2, 32'h0);
    cyc();
    reset2 = 1'b1;
    #1; chk("t6_rv3", 32'(rv2), 0);
    chk("t6_v3", 32'(ov2), 0);
    chk("t6_a3", oa2, 32'h0);
    chk("t6_i3", oi2, NOP);
    cyc();
    reset2 = 1'b0;
    #1; chk("t6_rv4", 32'(rv2), 1);
    chk("t6_ra4", ra2, 32'hFFFF_FFFC);
    chk("t6_v4", 32'(ov2), 0);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
